y_demux2_tdm: RTL

Y_DEMUX2_TDM -- requirements
Module: y_demux2_tdm

---
 rtl/y_demux2_tdm_pkg.sv | 7 +
 rtl/y_demux2_tdm_lane_reg.sv | 20 ++
 rtl/y_demux2_tdm.sv | 112 +++++++++++
 3 files changed

// File: rtl/y_demux2_tdm_pkg.sv
// Shared types and default sizing for the two-way TDM lane demultiplexer.
package y_demux2_tdm_pkg;
  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_e;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_LANES = 2;
endpackage

// File: rtl/y_demux2_tdm_lane_reg.sv
// One write-enabled lane slot of the frame shadow register.
module y_lane_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb q_d = we ? d : q_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;

  assign q = q_q;
endmodule

// File: rtl/y_demux2_tdm.sv
// Collects LANES time-multiplexed samples into one frame and presents it
// on a valid/ready output register; flags early restarts and overruns.
module y_demux2_tdm
  import y_demux2_tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int CNT_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   err_sync,
  output logic                   err_ovr
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  if (LANES < 2 || LANES > 16) begin : g_bad_lanes
    $error("y_demux2_tdm: LANES must be in 2..16");
  end

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0]              lane_we;
  logic [LANES-1:0][WIDTH-1:0]   shadow_q;
  logic [LANES-1:0][WIDTH-1:0]   frame_new;
  logic [LANES-1:0][WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          sync_q, sync_d;
  logic                          ovr_q, ovr_d;
  logic                          complete, load;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    y_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_we[k]),
      .d     (in_data),
      .q     (shadow_q[k])
    );
  end

  // Lane FSM: in_sof always restarts at lane 0, even on the final-lane slot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lane_we  = '0;
    sync_d   = 1'b0;
    complete = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        lane_we[0] = 1'b1;
        cnt_d      = CNT_W'(1);
        state_d    = COLLECT;
        sync_d     = (state_q == COLLECT);
      end else if (state_q == COLLECT) begin
        for (int k = 0; k < LANES; k++)
          if (cnt_q == CNT_W'(k)) lane_we[k] = 1'b1;
        if (cnt_q == LAST) begin
          complete = 1'b1;
          state_d  = HUNT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // The final lane lands in the shadow on the same edge the frame is loaded,
  // so splice it in here to keep the output load atomic.
  always_comb begin
    for (int k = 0; k < LANES; k++)
      frame_new[k] = lane_we[k] ? in_data : shadow_q[k];
  end

  always_comb begin
    load        = complete && (!out_valid_q || out_ready);
    ovr_d       = complete && out_valid_q && !out_ready;
    out_data_d  = load ? frame_new : out_data_q;
    out_valid_d = out_valid_q;
    if (load)                         out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_q      <= sync_d;
      ovr_q       <= ovr_d;
    end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_sync  = sync_q;
  assign err_ovr   = ovr_q;
endmodule
